controller_fsm: RTL
===================

# controller_fsm

Multi-cycle control unit for the 10-bit processor. It sequences the instruction register (IR), register file, A/G ALU registers and shared 10-bit bus through timesteps T0–T3. It loads the IR on an execute request, decodes the held instruction, and drives one-hot bus and register enables until the instruction completes.

## Interface
- No parameters.
- CLKb  in  1  processor clock; all state updates on the falling edge, matching IR and register file
- Clear  in  1  asynchronous, active-high reset
- Exec  in  1  execute request; sampled only in T0
- INST  in  10  IR output Q; field layout:
  - [9:8] Rx (destination)
  - [7:6] Ry (source)
  - [7:4] 4-bit immediate for ADDI/SUBI
  - [3:0] opcode
- IR_En  out  1  IR load enable
- Rin  out  4  one-hot register-file write enable
- Rout  out  4  one-hot register-file bus drive
- Ain  out  1  load A from bus
- Gin  out  1  load G from ALU
- Gout  out  1  G drives bus
- ExtEn  out  1  external data drives bus
- ImmEn  out  1  Imm drives bus
- Imm  out  10  {6'b0, INST[7:4]}, always valid
- ALUcont  out  4  ALU operation; equals INST[3:0]
- Done  out  1  final-timestep pulse
- Tstep  out  2  current timestep, for debug/display

## Operation
Opcodes (INST[3:0]):
- 0 LOAD: Rx ← external bus
- 1 COPY: Rx ← Ry
- 2 ADD, 3 SUB, 6 AND, 7 OR, 8 XOR: Rx ← Rx op Ry
- 4 INV: Rx ← ~Ry
- 5 FLP: Rx ← −Ry
- 9 ADDI, A SUBI: Rx ← Rx ± Imm
- B–F: NOP

State register Tstep ∈ {T0, T1, T2, T3}. Outputs are combinational from Tstep, INST and Exec. An enable not listed for a step is 0.
- T0: IR_En = Exec.
  - Exec=1 → T1.
  - Exec=0 → stay in T0.
- T1:
  - LOAD: ExtEn, Rin[Rx], Done → T0.
  - COPY: Rout[Ry], Rin[Rx], Done → T0.
  - NOP: Done → T0.
  - Binary and immediate ops: Rout[Rx], Ain → T2.
  - INV/FLP: Rout[Ry], Ain → T2.
- T2:
  - Binary ops: Rout[Ry], Gin → T3.
  - ADDI/SUBI: ImmEn, Gin → T3.
  - INV/FLP: Gin only → T3.
- T3: Gout, Rin[Rx], Done → T0.
- Invariant: at most one of ExtEn, ImmEn, Gout, any Rout bit is 1 in any cycle (single bus driver). Rin and Rout are each zero or one-hot.
- Rx = Ry is legal and needs no special handling.
- Exec asserted outside T0 is ignored. It is not queued.
- Arithmetic is modulo 2^10 in the ALU. The controller does no arithmetic.

## Timing
- Reset: Clear=1 forces Tstep=T0 immediately. While Clear=1, all enables, Done and IR_En are 0. Imm and ALUcont follow INST.
- Reset mid-instruction aborts it. No further Rin pulse occurs, and the next instruction needs a new Exec.
- The IR captures INST on the same falling edge that moves T0→T1, so decode in T1–T3 uses the new IR contents.
- Latency from the edge that samples Exec to Done:
  - 1 cycle for LOAD, COPY and NOP.
  - 3 cycles for ALU and immediate ops.
  - Done is high for exactly one cycle.
- Back-to-back: Exec held high re-enters T1 on the edge after the Done cycle, with no idle cycle.
- INST must stay stable in T1–T3. The IR guarantees this because IR_En=0 outside T0.

## Test plan
- Reset: assert Clear in T2 of an ADD → Tstep=0 asynchronously; all enables 0; no Rin pulse afterwards; ADD not completed.
- LOAD: INST=10'b10_00_00_0000, Exec pulse:
  - IR_En=1 in T0.
  - T1: ExtEn=1, Rin=4'b0100, Done=1.
  - Returns to T0.
- ADD R1,R3: INST=10'b01_11_00_0010:
  - T1: Rout=0010, Ain.
  - T2: Rout=1000, Gin, ALUcont=2.
  - T3: Gout, Rin=0010, Done.
- SUBI R0,#9: INST=10'b00_1001_1010:
  - T2: ImmEn=1, Imm=10'd9, ALUcont=A.
  - T3: Rin=0001, Done.
- Opcode F: Done in T1 with no Rin; Exec pulsed during T2 of an XOR is ignored (exactly one Done).
- Random 1000-instruction run checking the single-bus-driver and one-hot invariants every cycle.

Source files
------------

// File: rtl/controller_fsm.sv
// controller_fsm: multi-cycle control unit for the 10-bit processor.
// Sequences IR, register file, A/G ALU registers and the shared bus through T0..T3.
//
// Ports:
//   CLKb    in   processor clock, state advances on the falling edge
//   Clear   in   asynchronous active-high reset
//   Exec    in   execute request, honoured only in T0
//   INST    in   IR contents: [9:8] Rx, [7:6] Ry, [7:4] imm, [3:0] opcode
//   IR_En   out  IR load enable
//   Rin     out  one-hot register-file write enable
//   Rout    out  one-hot register-file bus drive
//   Ain     out  load A from bus
//   Gin     out  load G from ALU
//   Gout    out  G drives bus
//   ExtEn   out  external data drives bus
//   ImmEn   out  immediate drives bus
//   Imm     out  zero-extended 4-bit immediate
//   ALUcont out  ALU operation (opcode)
//   Done    out  final-timestep pulse
//   Tstep   out  current timestep
module controller_fsm (
  input  logic       CLKb,
  input  logic       Clear,
  input  logic       Exec,
  input  logic [9:0] INST,
  output logic       IR_En,
  output logic [3:0] Rin,
  output logic [3:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       ExtEn,
  output logic       ImmEn,
  output logic [9:0] Imm,
  output logic [3:0] ALUcont,
  output logic       Done,
  output logic [1:0] Tstep
);

  typedef enum logic [1:0] {StT0 = 2'd0, StT1 = 2'd1, StT2 = 2'd2, StT3 = 2'd3} state_e;

  localparam logic [3:0] OpLoad = 4'h0;
  localparam logic [3:0] OpCopy = 4'h1;
  localparam logic [3:0] OpAdd  = 4'h2;
  localparam logic [3:0] OpSub  = 4'h3;
  localparam logic [3:0] OpInv  = 4'h4;
  localparam logic [3:0] OpFlp  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpOr   = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpAddi = 4'h9;
  localparam logic [3:0] OpSubi = 4'hA;

  state_e     state_q, state_d;
  logic [3:0] op;
  logic [3:0] rx_oh, ry_oh;
  logic       is_load, is_copy, is_bin, is_un, is_imm;

  assign op      = INST[3:0];
  assign rx_oh   = 4'b0001 << INST[9:8];
  assign ry_oh   = 4'b0001 << INST[7:6];
  assign is_load = (op == OpLoad);
  assign is_copy = (op == OpCopy);
  assign is_bin  = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr) ||
                   (op == OpXor);
  assign is_un   = (op == OpInv) || (op == OpFlp);
  assign is_imm  = (op == OpAddi) || (op == OpSubi);

  assign Imm     = {6'b0, INST[7:4]};
  assign ALUcont = op;
  assign Tstep   = state_q;

  always_ff @(negedge CLKb or posedge Clear) begin
    if (Clear) begin
      state_q <= StT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    IR_En   = 1'b0;
    Rin     = 4'b0;
    Rout    = 4'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    ExtEn   = 1'b0;
    ImmEn   = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      StT0: begin
        // Clear already forces T0; gating here keeps IR_En low during reset.
        IR_En = Exec & ~Clear;
        if (Exec) state_d = StT1;
      end
      StT1: begin
        if (is_load) begin
          ExtEn   = 1'b1;
          Rin     = rx_oh;
          Done    = 1'b1;
          state_d = StT0;
        end else if (is_copy) begin
          Rout    = ry_oh;
          Rin     = rx_oh;
          Done    = 1'b1;
          state_d = StT0;
        end else if (is_bin || is_imm) begin
          Rout    = rx_oh;
          Ain     = 1'b1;
          state_d = StT2;
        end else if (is_un) begin
          Rout    = ry_oh;
          Ain     = 1'b1;
          state_d = StT2;
        end else begin
          Done    = 1'b1;
          state_d = StT0;
        end
      end
      StT2: begin
        if (is_bin) begin
          Rout    = ry_oh;
          Gin     = 1'b1;
          state_d = StT3;
        end else if (is_imm) begin
          ImmEn   = 1'b1;
          Gin     = 1'b1;
          state_d = StT3;
        end else if (is_un) begin
          Gin     = 1'b1;
          state_d = StT3;
        end else begin
          // Unreachable with a stable IR; recover to idle.
          state_d = StT0;
        end
      end
      StT3: begin
        Gout    = 1'b1;
        Rin     = rx_oh;
        Done    = 1'b1;
        state_d = StT0;
      end
      default: state_d = StT0;
    endcase
  end

endmodule
